// File: rtl/loteria_escalonador.sv
// loteria_escalonador: round-robin scheduler that serves four players' lottery
// tickets to a shared checker, one digit per cycle, and returns the result.
// Optional feature macro: LOTERIA_CONTADOR_EN adds the 16-bit 'wins' output
// with four saturating 4-bit per-player win counters.
module loteria_escalonador #(
   parameter int unsigned N_DIG = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [3:0]           req,
   input  logic [16*N_DIG-1:0]  ticket,
   output logic [3:0]           gnt,
   output logic [3:0]           numero,
   output logic                 insere,
   output logic                 fim_jogo,
   input  logic [1:0]           premio,
   output logic                 done,
   output logic [1:0]           done_id,
   output logic [1:0]           done_premio,
   output logic                 busy
`ifdef LOTERIA_CONTADOR_EN
   ,
   output logic [15:0]          wins
`endif
);

   localparam int unsigned TW    = 4 * N_DIG;
   localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SEND   = 3'd1;
   localparam logic [2:0] S_FINISH = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TW-1:0]    tkt_q, tkt_d;
   logic [1:0]       id_q, id_d;

   logic [3:0]       gnt_q, gnt_d;
   logic [3:0]       numero_q, numero_d;
   logic             insere_q, insere_d;
   logic             fim_q, fim_d;
   logic             done_q, done_d;
   logic [1:0]       done_id_q, done_id_d;
   logic [1:0]       done_premio_q, done_premio_d;
   logic             busy_q, busy_d;

   logic [1:0]       winner;
   logic [1:0]       cand;
   logic             found;
   logic [TW-1:0]    sel_tkt;
   logic [IDX_W-1:0] idx_nxt;
   logic [3:0]       dig_nxt;

   // Round-robin search starting at ptr, plus the ticket of the candidate winner
   always_comb begin
      winner = 2'd0;
      cand   = 2'd0;
      found  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cand = 2'(ptr_q + 2'(k));
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      sel_tkt = TW'(ticket >> (int'(winner) * TW));
      idx_nxt = IDX_W'(idx_q + 1'b1);
      dig_nxt = 4'(tkt_q >> (int'(idx_nxt) * 4));
   end

   // Next state and next values of every registered output
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      idx_d         = idx_q;
      tkt_d         = tkt_q;
      id_d          = id_q;
      gnt_d         = 4'b0000;
      numero_d      = 4'd0;
      insere_d      = 1'b0;
      fim_d         = 1'b0;
      done_d        = 1'b0;
      done_id_d     = done_id_q;
      done_premio_d = done_premio_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d  = S_SEND;
               tkt_d    = sel_tkt;
               id_d     = winner;
               ptr_d    = 2'(winner + 2'd1);
               idx_d    = '0;
               gnt_d    = 4'(4'b0001 << winner);
               insere_d = 1'b1;
               numero_d = sel_tkt[3:0];
            end
         end
         S_SEND: begin
            if (idx_q == IDX_W'(N_DIG - 1)) begin
               state_d = S_FINISH;
               idx_d   = '0;
               fim_d   = 1'b1;
            end else begin
               idx_d    = idx_nxt;
               insere_d = 1'b1;
               numero_d = dig_nxt;
            end
         end
         S_FINISH: begin
            state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            state_d       = S_REPORT;
            done_d        = 1'b1;
            done_id_d     = id_q;
            done_premio_d = premio;
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any game in progress
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= 2'd0;
         idx_q         <= '0;
         tkt_q         <= '0;
         id_q          <= 2'd0;
         gnt_q         <= 4'b0000;
         numero_q      <= 4'd0;
         insere_q      <= 1'b0;
         fim_q         <= 1'b0;
         done_q        <= 1'b0;
         done_id_q     <= 2'd0;
         done_premio_q <= 2'd0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         idx_q         <= idx_d;
         tkt_q         <= tkt_d;
         id_q          <= id_d;
         gnt_q         <= gnt_d;
         numero_q      <= numero_d;
         insere_q      <= insere_d;
         fim_q         <= fim_d;
         done_q        <= done_d;
         done_id_q     <= done_id_d;
         done_premio_q <= done_premio_d;
         busy_q        <= busy_d;
      end
   end

   assign gnt         = gnt_q;
   assign numero      = numero_q;
   assign insere      = insere_q;
   assign fim_jogo    = fim_q;
   assign done        = done_q;
   assign done_id     = done_id_q;
   assign done_premio = done_premio_q;
   assign busy        = busy_q;

`ifdef LOTERIA_CONTADOR_EN
   logic [15:0] wins_q, wins_d;

   // Count a win for the served player during REPORT, saturating at 15
   always_comb begin
      wins_d = wins_q;
      if ((state_q == S_REPORT) && (done_premio_q != 2'b00) &&
          (wins_q[4*id_q +: 4] != 4'hF)) begin
         wins_d[4*id_q +: 4] = 4'(wins_q[4*id_q +: 4] + 4'd1);
      end
   end

   // Win counter register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wins_q <= 16'd0;
      end else begin
         wins_q <= wins_d;
      end
   end

   assign wins = wins_q;
`endif

endmodule

// File: tb/tb_loteria_escalonador.sv
// Scoreboard bench for loteria_escalonador: the stimulus side predicts each
// game (winner, digits, result) and queues it; the monitor checks the DUT's
// cycle-by-cycle behaviour whenever a grant appears.
module tb_loteria_escalonador;

   localparam int unsigned N_DIG = 5;
   localparam int unsigned TW    = 4 * N_DIG;

   logic                clock = 1'b0;
   logic                reset;
   logic [3:0]          req;
   logic [16*N_DIG-1:0] ticket;
   logic [3:0]          gnt;
   logic [3:0]          numero;
   logic                insere;
   logic                fim_jogo;
   logic [1:0]          premio;
   logic                done;
   logic [1:0]          done_id;
   logic [1:0]          done_premio;
   logic                busy;
`ifdef LOTERIA_CONTADOR_EN
   logic [15:0]         wins;
`endif

   loteria_escalonador #(.N_DIG(N_DIG)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .ticket      (ticket),
      .gnt         (gnt),
      .numero      (numero),
      .insere      (insere),
      .fim_jogo    (fim_jogo),
      .premio      (premio),
      .done        (done),
      .done_id     (done_id),
      .done_premio (done_premio),
      .busy        (busy)
`ifdef LOTERIA_CONTADOR_EN
      ,
      .wins        (wins)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      int            id;
      logic [TW-1:0] digs;
      logic [1:0]    prem;
      int            abort_at;
      bit            chk_gap;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ptr_m = 0;
   int   last_gnt = 0;
   int   wins_m[4];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [16*N_DIG-1:0] rand_ticket();
      logic [16*N_DIG-1:0] v;
      for (int b = 0; b < 16*N_DIG; b++) v[b] = 1'($urandom);
      return v;
   endfunction

   // Checks one game from its grant cycle (offset 0) through the idle cycle after done
   task automatic check_game(input exp_t e);
      logic [3:0]    oh;
      logic [3:0]    dig;
      logic [TW-1:0] d;
      bit            seen;
      oh   = 4'(4'b0001 << e.id);
      d    = e.digs;
      seen = 1'b0;
      chk("gnt_onehot", 32'(gnt), 32'(oh));
      // a grant at cycle 1 is followed at the earliest by one at cycle N_DIG+5
      if (e.chk_gap) chk("gnt_spacing", 32'(cyc - last_gnt), 32'(N_DIG + 4));
      last_gnt = cyc;
      for (int k = 0; k < N_DIG; k++) begin
         if (k > 0) @(negedge clock);
         if (e.abort_at != 0 && k >= e.abort_at) begin
            repeat (N_DIG + 4) begin
               @(negedge clock);
               if (done === 1'b1) seen = 1'b1;
            end
            chk("no_done_after_abort", 32'(seen), 32'(0));
            return;
         end
         dig = d[4*k +: 4];
         chk("send_insere", 32'(insere), 32'(1));
         chk("send_numero", 32'(numero), 32'(dig));
         chk("send_busy", 32'(busy), 32'(1));
         if (k > 0) chk("gnt_single_cycle", 32'(gnt), 32'(0));
      end
      @(negedge clock);
      chk("finish_fim", 32'(fim_jogo), 32'(1));
      chk("finish_insere", 32'(insere), 32'(0));
      chk("finish_numero", 32'(numero), 32'(0));
      @(negedge clock);
      chk("sample_fim_low", 32'(fim_jogo), 32'(0));
      chk("sample_done_low", 32'(done), 32'(0));
      @(negedge clock);
      chk("report_done", 32'(done), 32'(1));
      chk("report_id", 32'(done_id), 32'(e.id));
      chk("report_premio", 32'(done_premio), 32'(e.prem));
`ifdef LOTERIA_CONTADOR_EN
      if (e.prem != 2'b00 && wins_m[e.id] < 15) wins_m[e.id]++;
`endif
      @(negedge clock);
      chk("done_pulse", 32'(done), 32'(0));
      chk("hold_id", 32'(done_id), 32'(e.id));
      chk("hold_premio", 32'(done_premio), 32'(e.prem));
      chk("idle_busy", 32'(busy), 32'(0));
`ifdef LOTERIA_CONTADOR_EN
      chk("wins", 32'(wins[4*e.id +: 4]), 32'(wins_m[e.id]));
`endif
   endtask

   // Monitor: every grant pops the predicted game and checks it
   initial begin
      forever begin
         @(negedge clock);
         if (reset === 1'b0 && gnt !== 4'b0000) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_gnt: got %b expected no grant", gnt);
            end else begin
               check_game(sb.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      ptr_m = 0;
      for (int i = 0; i < 4; i++) wins_m[i] = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Drives one game; the winner is predicted from the pointer and req
   task automatic run_game(input logic [3:0] r, input logic [16*N_DIG-1:0] t,
                           input logic [1:0] prem, input bit scramble,
                           input int abort_at, input bit gap);
      exp_t e;
      int   w;
      bit   ok;
      req    = r;
      ticket = t;
      w = -1;
      for (int k = 0; k < 4; k++)
         if (w < 0 && r[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
      e.id       = w;
      e.digs     = t[w*TW +: TW];
      e.prem     = prem;
      e.abort_at = abort_at;
      e.chk_gap  = gap;
      sb.push_back(e);
      ptr_m = (w + 1) % 4;

      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clock);
         if (gnt !== 4'b0000) ok = 1'b1;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL gnt_timeout: got no grant expected player %0d", w);
         sb.delete();
         return;
      end

      if (abort_at != 0) begin
         repeat (abort_at) @(negedge clock);
         #2 reset = 1'b1;
         #1;
         chk("abort_insere", 32'(insere), 32'(0));
         chk("abort_busy", 32'(busy), 32'(0));
         chk("abort_numero", 32'(numero), 32'(0));
         req   = 4'b0000;
         ptr_m = 0;
         for (int i = 0; i < 4; i++) wins_m[i] = 0;
         repeat (2) @(negedge clock);
         reset = 1'b0;
         repeat (N_DIG + 6) @(negedge clock);
         return;
      end

      if (scramble) begin
         req    = 4'($urandom);
         ticket = rand_ticket();
      end
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clock);
         if (fim_jogo === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL fim_timeout: got no fim_jogo expected one for player %0d", w);
         return;
      end
      premio = 2'($urandom);
      @(negedge clock);
      premio = prem;
      @(negedge clock);
      premio = 2'($urandom);
      if (scramble) req = 4'b0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [16*N_DIG-1:0] t;
      logic [3:0]          r;
      reset  = 1'b1;
      req    = 4'b0000;
      ticket = '0;
      premio = 2'b00;
      for (int i = 0; i < 4; i++) wins_m[i] = 0;
      repeat (2) @(negedge clock);
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_numero", 32'(numero), 32'(0));
      chk("rst_insere", 32'(insere), 32'(0));
      chk("rst_fim", 32'(fim_jogo), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_done_id", 32'(done_id), 32'(0));
      chk("rst_done_premio", 32'(done_premio), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      reset = 1'b0;
      @(negedge clock);

      // single request with digits 5,3,8,2,0
      t = '0;
      t[TW-1:0] = 20'h02835;
      run_game(4'b0001, t, 2'b01, 1'b0, 0, 1'b0);
      req = 4'b0000;
      repeat (3) @(negedge clock);
      run_game(4'b0001, rand_ticket(), 2'b11, 1'b0, 0, 1'b0);
      req = 4'b0000;
      repeat (3) @(negedge clock);

      // fairness with all four requesting after reset
      do_reset();
      t = rand_ticket();
      for (int g = 0; g < 5; g++) run_game(4'b1111, t, 2'(g), 1'b0, 0, g > 0);
      req = 4'b0000;
      repeat (3) @(negedge clock);

      // pointer wrap: serve player 3, then 1001 gives 0 then 3
      run_game(4'b1000, rand_ticket(), 2'b10, 1'b0, 0, 1'b0);
      req = 4'b0000;
      repeat (3) @(negedge clock);
      t = rand_ticket();
      run_game(4'b1001, t, 2'b01, 1'b0, 0, 1'b0);
      run_game(4'b1001, t, 2'b00, 1'b0, 0, 1'b1);
      req = 4'b0000;
      repeat (3) @(negedge clock);

      // reset during the third SEND cycle, then a fresh request from player 1
      run_game(4'b0100, rand_ticket(), 2'b01, 1'b0, 2, 1'b0);
      run_game(4'b0010, rand_ticket(), 2'b11, 1'b0, 0, 1'b0);
      req = 4'b0000;
      repeat (2) @(negedge clock);

      // random traffic with req and ticket disturbed during each game
      for (int g = 0; g < 24; g++) begin
         r = 4'($urandom_range(1, 15));
         run_game(r, rand_ticket(), 2'($urandom), 1'b1, 0, 1'b0);
      end
      req = 4'b0000;

`ifdef LOTERIA_CONTADOR_EN
      // counter saturation for player 2, then a losing game
      repeat (3) @(negedge clock);
      do_reset();
      for (int g = 0; g < 16; g++)
         run_game(4'b0100, rand_ticket(), 2'($urandom_range(1, 3)), 1'b0, 0, 1'b0);
      run_game(4'b0100, rand_ticket(), 2'b00, 1'b0, 0, 1'b0);
      req = 4'b0000;
`endif

      repeat (N_DIG + 8) @(negedge clock);
      chk("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
